ball_feed_arbiter: RTL and testbench
====================================

# ball_feed_arbiter

Controller that shares the single ball chute in front of the RGB ball detector among three colour hoppers (green, blue, red). Each cycle it can issue one ball onto the chute using a valid/ready handshake. It favours colours missing from the current non-overlapping R/G/B group, so triples complete as early as possible. It also tracks group completion itself and keeps a count of finished triples for the status logic.

## Interface
Parameters:
- CNT_W, 8, width of the completed-triple counter
- STRICT, 0, when 1 only colours missing from the current group are issued; when 0 a repeat colour is issued if no missing colour is requested

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; one clock domain only
- enable  in  1  arbitration enable; when low, no new ball is offered
- clr  in  1  synchronous clear of group mask and counter (priority below rst)
- req  in  3  hopper non-empty; index = colour code (bit0 G, bit1 B, bit2 R)
- gnt  out  3  one-hot, high in the transfer cycle only; tells the hopper to release one ball
- ball_vld  out  1  chute offer valid
- ball_col  out  2  colour on chute: G=2'b00, B=2'b01, R=2'b10; 2'b11 never driven
- ball_rdy  in  1  chute/detector accepts the ball
- seen  out  3  colour mask of the current group
- triple_done  out  1  one-cycle pulse when a group completes
- triple_cnt  out  CNT_W  completed groups, saturating at all-ones

## Operation
- FSM with two states:
  - IDLE: ball_vld=0.
  - OFFER: ball_vld=1, ball_col held stable.
- Candidate set:
  - miss = req & ~seen_nx.
  - pick = miss if miss≠0.
  - Otherwise pick = req when STRICT=0, or pick = 0 when STRICT=1.
- Round-robin inside pick: search order starts at ptr, then ptr+1, ptr+2 (mod 3). ptr = colour after the last granted colour.
- IDLE→OFFER: enable=1 and pick≠0. The winner's colour is registered into ball_col.
- Transfer: OFFER with ball_rdy=1. In that cycle:
  - gnt = onehot(ball_col).
  - seen_nx = seen | onehot(ball_col), or 000 when that OR equals 111.
  - ptr advances past ball_col.
- After a transfer, re-arbitrate in the same cycle using seen_nx. If enable=1 and pick≠0, stay in OFFER with the new colour (back-to-back, no bubble). Otherwise go to IDLE.
- A hopper with req held high may win consecutive slots (multiple balls).
- Group completion: a transfer makes the mask 111. Then:
  - seen clears to 000.
  - triple_done pulses on the next cycle.
  - triple_cnt increments, saturating, holds at 2^CNT_W−1.
- req changes and enable deassertion never withdraw or alter an active offer. The ball stays offered until ball_rdy.
- clr:
  - seen=0, triple_cnt=0, triple_done=0.
  - An offer in progress completes normally.
  - If clr and a transfer coincide, clr wins for seen and triple_cnt. gnt still fires.

## Timing
- Reset values: state=IDLE, ball_vld=0, ball_col=2'b00, gnt=000, seen=000, triple_done=0, triple_cnt=0, ptr=G.
- Latency from req rising in IDLE to ball_vld: 1 cycle.
- Throughput: 1 ball/cycle while ball_rdy=1 and pick≠0.
- gnt is combinational from state and ball_rdy, high for exactly the transfer cycle.
- All other outputs are registered.
- Reset asserted mid-offer drops ball_vld immediately. No gnt is issued for that ball.

## Structure
- Shared package holds:
  - colour codes GC=2'b00, BC=2'b01, RC=2'b10
  - FSM state encodings IDLE/OFFER
  - these colour codes are the ones already used by the detector
- Sub-module rr_pick3: combinational 3-way round-robin picker. Inputs are the 3-bit pick vector and 2-bit ptr. Outputs are a valid flag and the 2-bit winner colour.

## Test plan
- Reset with req=111, enable=1:
  - cycle 1: ball_col=G.
  - with ball_rdy=1, sequence G,B,R.
  - triple_done pulses once, triple_cnt=1, seen returns to 000.
- Missing-colour priority: req=011, G accepted (seen=001), then req=111 → next ball is B, not G; then R.
- STRICT=1, seen=011, req=011 → ball_vld stays 0. Raising req[2] gives R one cycle later.
- Backpressure: ball_rdy=0 for 5 cycles while req toggles and enable drops → ball_col stable, gnt=000 throughout. gnt fires only in the cycle ball_rdy rises.
- Saturation and clr:
  - CNT_W=2, 4 triples → triple_cnt stays 3.
  - clr coincident with the completing transfer → triple_cnt=0, seen=000, gnt still asserted.
- Async rst low mid-offer → ball_vld=0 without a clock edge, and no gnt. After release, arbitration restarts at G.

Source files
------------

// File: rtl/ball_feed_arbiter_pkg.sv
// Shared colour codes and FSM encodings for the ball chute arbiter and the detector.
// Pure definitions: no latency, no backpressure.
package ball_feed_arbiter_pkg;

    typedef logic [1:0] col_t;

    localparam col_t GC = 2'b00;
    localparam col_t BC = 2'b01;
    localparam col_t RC = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    function automatic col_t next_col(input col_t c);
        return (c == RC) ? GC : col_t'(c + 2'd1);
    endfunction

    function automatic logic [2:0] col_onehot(input col_t c);
        return 3'b001 << c;
    endfunction

endpackage

// File: rtl/ball_feed_arbiter_if.sv
// Hopper/chute/status bundle; master is the arbiter, slave is the surrounding logic.
// Signals only: no latency, valid/ready on the chute side.
interface ball_feed_arbiter_if #(
    parameter int CNT_W = 8
);
    import ball_feed_arbiter_pkg::*;

    logic             enable;
    logic             clr;
    logic [2:0]       req;
    logic [2:0]       gnt;
    logic             ball_vld;
    col_t             ball_col;
    logic             ball_rdy;
    logic [2:0]       seen;
    logic             triple_done;
    logic [CNT_W-1:0] triple_cnt;

    modport master (
        input  enable, clr, req, ball_rdy,
        output gnt, ball_vld, ball_col, seen, triple_done, triple_cnt
    );

    modport slave (
        output enable, clr, req, ball_rdy,
        input  gnt, ball_vld, ball_col, seen, triple_done, triple_cnt
    );

endinterface

// File: rtl/ball_feed_arbiter_rr_pick3.sv
// Three-way round-robin picker: first set bit of i_pick searching from i_ptr upward mod 3.
// Purely combinational; no backpressure.
module ball_feed_arbiter_rr_pick3
    import ball_feed_arbiter_pkg::*;
(
    input  logic [2:0] i_pick,
    input  col_t       i_ptr,
    output logic       o_vld,
    output col_t       o_col
);

    col_t w_c1;
    col_t w_c2;

    assign w_c1 = next_col(i_ptr);
    assign w_c2 = next_col(w_c1);

    // Later assignments override earlier ones, so the search order reads bottom-up.
    always_comb begin
        o_vld = |i_pick;
        o_col = GC;
        if ((i_pick & col_onehot(w_c2)) != 3'b000)  o_col = w_c2;
        if ((i_pick & col_onehot(w_c1)) != 3'b000)  o_col = w_c1;
        if ((i_pick & col_onehot(i_ptr)) != 3'b000) o_col = i_ptr;
    end

endmodule

// File: rtl/ball_feed_arbiter.sv
// Shares the detector chute among G/B/R hoppers, favouring colours missing from the current triple.
// Offer 1 cycle after request; back-to-back while ready; an offer is held untouched until ball_rdy.
module ball_feed_arbiter
    import ball_feed_arbiter_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int STRICT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    ball_feed_arbiter_if.master  bus
);

    state_e           r_state;
    state_e           w_state_nx;
    col_t             r_col;
    col_t             w_col_nx;
    col_t             r_ptr;
    logic [2:0]       r_seen;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic       w_xfer;
    logic [2:0] w_seen_or;
    logic       w_complete;
    logic [2:0] w_seen_nx;
    col_t       w_ptr_nx;
    logic [2:0] w_miss;
    logic [2:0] w_pick;
    logic       w_win_vld;
    col_t       w_win_col;

    assign w_xfer     = (r_state == OFFER) && bus.ball_rdy;
    assign w_seen_or  = r_seen | (w_xfer ? col_onehot(r_col) : 3'b000);
    assign w_complete = w_xfer && (w_seen_or == 3'b111);
    assign w_seen_nx  = w_complete ? 3'b000 : w_seen_or;
    assign w_ptr_nx   = w_xfer ? next_col(r_col) : r_ptr;

    // Arbitration sees the mask and pointer as they will be after this cycle's transfer.
    assign w_miss = bus.req & ~w_seen_nx;
    assign w_pick = (w_miss != 3'b000) ? w_miss : ((STRICT != 0) ? 3'b000 : bus.req);

    ball_feed_arbiter_rr_pick3 u_pick (
        .i_pick (w_pick),
        .i_ptr  (w_ptr_nx),
        .o_vld  (w_win_vld),
        .o_col  (w_win_col)
    );

    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        case (r_state)
            IDLE: begin
                if (bus.enable && w_win_vld) begin
                    w_state_nx = OFFER;
                    w_col_nx   = w_win_col;
                end
            end
            OFFER: begin
                if (bus.ball_rdy) begin
                    if (bus.enable && w_win_vld) begin
                        w_col_nx = w_win_col;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_col   <= GC;
            r_ptr   <= GC;
        end else begin
            r_state <= w_state_nx;
            r_col   <= w_col_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    // clr only touches group/status state; the chute handshake runs on regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seen <= 3'b000;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (bus.clr) begin
            r_seen <= 3'b000;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_seen <= w_seen_nx;
            r_done <= w_complete;
            if (w_complete && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.gnt         = w_xfer ? col_onehot(r_col) : 3'b000;
    assign bus.ball_vld    = (r_state == OFFER);
    assign bus.ball_col    = r_col;
    assign bus.seen        = r_seen;
    assign bus.triple_done = r_done;
    assign bus.triple_cnt  = r_cnt;

endmodule

// File: tb/tb_ball_feed_arbiter.sv
// Bench for ball_feed_arbiter: two instances (lenient CNT_W=2, strict CNT_W=8) share one stimulus.
// A set-level model is compared every cycle; directed literals pin the model to known sequences.
module tb_ball_feed_arbiter;
    import ball_feed_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       en  = 1'b0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ball_feed_arbiter_if #(.CNT_W(2)) bus0();
    ball_feed_arbiter_if #(.CNT_W(8)) bus1();

    assign bus0.enable = en;  assign bus1.enable = en;
    assign bus0.clr = clr;    assign bus1.clr = clr;
    assign bus0.req = req;    assign bus1.req = req;
    assign bus0.ball_rdy = rdy; assign bus1.ball_rdy = rdy;

    ball_feed_arbiter #(.CNT_W(2), .STRICT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ball_feed_arbiter #(.CNT_W(8), .STRICT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int o_vld[2], o_col[2], o_gnt[2], o_seen[2], o_done[2], o_cnt[2];
    always_comb begin
        o_vld[0] = int'(bus0.ball_vld);     o_vld[1] = int'(bus1.ball_vld);
        o_col[0] = int'(bus0.ball_col);     o_col[1] = int'(bus1.ball_col);
        o_gnt[0] = int'(bus0.gnt);          o_gnt[1] = int'(bus1.gnt);
        o_seen[0] = int'(bus0.seen);        o_seen[1] = int'(bus1.seen);
        o_done[0] = int'(bus0.triple_done); o_done[1] = int'(bus1.triple_done);
        o_cnt[0] = int'(bus0.triple_cnt);   o_cnt[1] = int'(bus1.triple_cnt);
    end

    task automatic chk(input string name, input int k, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s inst%0d t=%0t got %0d expected %0d", name, k, $time, got, exp);
    endtask

    task automatic chk2(input string name, input int idx_sel, input int exp);
        for (int k = 0; k < 2; k++) begin
            case (idx_sel)
                0: chk(name, k, o_vld[k], exp);
                1: chk(name, k, o_col[k], exp);
                2: chk(name, k, o_gnt[k], exp);
                3: chk(name, k, o_seen[k], exp);
                4: chk(name, k, o_done[k], exp);
                default: chk(name, k, o_cnt[k], exp);
            endcase
        end
    endtask

    // Model: an offer (present, colour), the set of colours in the group, the colour after the last grant.
    localparam int STR[2]  = '{0, 1};
    localparam int MAXC[2] = '{3, 255};
    bit       m_off[2]  = '{0, 0};
    int       m_col[2]  = '{0, 0};
    int       m_ptr[2]  = '{0, 0};
    bit [2:0] m_seen[2] = '{3'b000, 3'b000};
    int       m_cnt[2]  = '{0, 0};
    bit       m_done[2] = '{0, 0};

    always @(posedge clk or negedge rst) begin
        bit       xfer;
        bit       full;
        bit [2:0] s;
        bit [2:0] pick;
        int       p;
        int       win;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_off[k] = 0; m_col[k] = 0; m_ptr[k] = 0;
                m_seen[k] = 3'b000; m_cnt[k] = 0; m_done[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                xfer = m_off[k] && rdy;
                s    = m_seen[k];
                p    = m_ptr[k];
                full = 0;
                if (xfer) begin
                    s[m_col[k]] = 1'b1;
                    p = (m_col[k] + 1) % 3;
                    if (s == 3'b111) begin full = 1; s = 3'b000; end
                end
                pick = req & ~s;
                if (pick == 3'b000 && STR[k] == 0) pick = req;
                win = -1;
                for (int j = 0; j < 3; j++)
                    if (win < 0 && pick[(p + j) % 3]) win = (p + j) % 3;
                if (!(m_off[k] && !rdy)) begin
                    if (en && win >= 0) begin m_off[k] = 1; m_col[k] = win; end
                    else m_off[k] = 0;
                end
                m_ptr[k] = p;
                if (clr) begin
                    m_seen[k] = 3'b000; m_cnt[k] = 0; m_done[k] = 0;
                end else begin
                    m_seen[k] = s;
                    m_done[k] = full;
                    if (full && m_cnt[k] < MAXC[k]) m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("m_vld", k, o_vld[k], int'(m_off[k]));
            if (m_off[k]) chk("m_col", k, o_col[k], m_col[k]);
            chk("m_gnt", k, o_gnt[k], (m_off[k] && rdy) ? (1 << m_col[k]) : 0);
            chk("m_seen", k, o_seen[k], int'(m_seen[k]));
            chk("m_done", k, o_done[k], int'(m_done[k]));
            chk("m_cnt", k, o_cnt[k], m_cnt[k]);
        end
    end

    task automatic cyc(input logic [2:0] rq, input logic e, input logic r, input logic c);
        @(posedge clk);
        #1;
        req = rq; en = e; rdy = r; clr = c;
        @(negedge clk);
    endtask

    logic [2:0] bp_req[5];
    logic       bp_en[5];

    initial begin
        bp_req = '{3'b010, 3'b101, 3'b000, 3'b111, 3'b011};
        bp_en  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        #1 rst = 1'b0;
        #1;
        chk2("rst_vld", 0, 0);
        chk2("rst_gnt", 2, 0);
        chk2("rst_seen", 3, 0);
        chk2("rst_cnt", 5, 0);
        req = 3'b111; en = 1'b1; rdy = 1'b1;
        #1 rst = 1'b1;

        // G, B, R back to back, then the triple completes
        cyc(3'b111, 1, 1, 0);
        chk2("seq_col_g", 1, 0); chk2("seq_gnt_g", 2, 1);
        cyc(3'b111, 1, 1, 0);
        chk2("seq_col_b", 1, 1); chk2("seq_seen_g", 3, 1);
        cyc(3'b111, 1, 1, 0);
        chk2("seq_col_r", 1, 2); chk2("seq_seen_gb", 3, 3);
        cyc(3'b000, 1, 0, 0);
        chk2("trip_done", 4, 1); chk2("trip_cnt", 5, 1); chk2("trip_seen", 3, 0);
        chk2("trip_next_g", 1, 0);

        // Stalled offer ignores req and enable changes
        for (int i = 0; i < 5; i++) begin
            cyc(bp_req[i], bp_en[i], 0, 0);
            chk2("bp_vld", 0, 1); chk2("bp_col", 1, 0); chk2("bp_gnt", 2, 0);
            if (i == 0) chk2("done_once", 4, 0);
        end
        cyc(3'b000, 0, 1, 0);
        chk2("bp_release_gnt", 2, 1);
        cyc(3'b000, 0, 0, 0);
        chk2("idle_vld", 0, 0); chk2("idle_seen", 3, 1);

        // Async reset in the middle of an R offer
        cyc(3'b100, 1, 0, 0);
        chk2("lat_vld0", 0, 0);
        cyc(3'b100, 1, 0, 0);
        chk2("lat_vld1", 0, 1); chk2("lat_col", 1, 2);
        @(posedge clk);
        #2;
        rst = 1'b0; rdy = 1'b1;
        #1;
        chk2("arst_vld", 0, 0); chk2("arst_gnt", 2, 0);
        @(negedge clk);
        #2;
        req = 3'b011; en = 1'b1; rdy = 1'b0;
        rst = 1'b1;

        // Missing-colour priority, strict starvation, then late R
        cyc(3'b111, 1, 1, 0);
        chk2("rs_col_g", 1, 0); chk2("rs_gnt_g", 2, 1);
        cyc(3'b011, 1, 1, 0);
        chk2("miss_col_b", 1, 1); chk2("miss_seen", 3, 1);
        cyc(3'b011, 1, 1, 0);
        chk("lenient_col", 0, o_col[0], 0); chk("strict_vld", 1, o_vld[1], 0);
        chk("strict_seen", 1, o_seen[1], 3);
        cyc(3'b111, 1, 1, 0);
        chk("strict_vld_hold", 1, o_vld[1], 0); chk("lenient_col_b", 0, o_col[0], 1);
        cyc(3'b000, 1, 0, 0);
        chk2("late_r_vld", 0, 1); chk2("late_r_col", 1, 2);

        // clr coincident with the completing transfer
        cyc(3'b000, 0, 1, 1);
        chk2("clr_gnt", 2, 4);
        cyc(3'b000, 0, 0, 0);
        chk2("clr_seen", 3, 0); chk2("clr_cnt", 5, 0); chk2("clr_done", 4, 0);

        // Four triples: CNT_W=2 saturates at 3
        for (int i = 0; i < 14; i++) cyc(3'b111, 1, 1, 0);
        cyc(3'b000, 0, 0, 0);
        cyc(3'b000, 0, 0, 0);
        chk("sat_cnt", 0, o_cnt[0], 3);
        chk("wide_cnt", 1, o_cnt[1], 4);
        chk2("sat_seen", 3, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
